// File: rtl/simd_pkg.sv
// Shared constants and types for the SIMD unit front end.
// Holds the instruction format, the NOP encoding and the fetch FSM states.
package simd_pkg;

  localparam int INSTR_W     = 25;
  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/simd_instr_fetch_if.sv
// Loader/hazard-side bundle of the instruction fetch stage.
// The master drives load, start, stall and clear; the fetch stage is the slave.
interface simd_instr_fetch_if #(
  parameter int INSTR_W = simd_pkg::INSTR_W,
  parameter int ADDR_W  = simd_pkg::IMEM_ADDR_W
);

  logic               clear;
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_instr;
  logic               ld_full;
  logic               start;
  logic               stall;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;

  modport master (
    output clear, ld_valid, ld_instr, start, stall,
    input  ld_full, instr, instr_valid, pc, busy, done
  );

  modport slave (
    input  clear, ld_valid, ld_instr, start, stall,
    output ld_full, instr, instr_valid, pc, busy, done
  );

endinterface

// File: rtl/simd_instr_mem.sv
// Instruction buffer: synchronous write, asynchronous read, contents not reset.
// Zero-latency read; no backpressure (the owner gates writes).
module simd_instr_mem #(
  parameter int INSTR_W = simd_pkg::INSTR_W,
  parameter int DEPTH   = simd_pkg::IMEM_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simd_instr_fetch.sv
// Fetch stage: loads the buffer in IDLE, then streams one instruction per cycle in RUN.
// Start-to-first-instruction is one cycle; stall freezes instr, instr_valid and pc.
module simd_instr_fetch #(
  parameter int INSTR_W = simd_pkg::INSTR_W,
  parameter int DEPTH   = simd_pkg::IMEM_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  simd_instr_fetch_if.slave bus
);

  import simd_pkg::*;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] rdata;
  logic               mem_we;
  logic               full;

  assign full = (count_q == FULL_CNT);

  simd_instr_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.ld_instr),
    .raddr (pc_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    vld_d    = vld_q;
    mem_we   = 1'b0;
    if (bus.clear) begin
      state_d  = IDLE;
      count_d  = '0;
      wr_ptr_d = '0;
      pc_d     = '0;
      instr_d  = INSTR_W'(NOP_INSTR);
      vld_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          vld_d = 1'b0;
          // A load in the same cycle as start wins; start is simply lost.
          if (bus.ld_valid) begin
            if (!full) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_q + 1'b1;
            end
          end else if (bus.start && (count_q != '0)) begin
            state_d = RUN;
            pc_d    = '0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            instr_d = rdata;
            vld_d   = 1'b1;
            pc_d    = pc_q + 1'b1;
            if ({1'b0, pc_q} == count_q - 1'b1) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (!bus.stall) begin
            instr_d = INSTR_W'(NOP_INSTR);
            vld_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ld_full     = full;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_simd_instr_fetch.sv
// Bench for simd_instr_fetch: directed scenarios plus randomized load/stream/stall runs.
// A queue model of the buffer feeds an expected-stream scoreboard drained by a monitor.
module tb_simd_instr_fetch;

  import simd_pkg::*;

  localparam int DEPTH = IMEM_DEPTH;
  localparam int AW    = IMEM_ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  simd_instr_fetch_if #(.INSTR_W(INSTR_W), .ADDR_W(AW)) bus ();

  simd_instr_fetch #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  instr_t model_buf[$];
  instr_t exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(instr_t v);
    bus.ld_valid = 1'b1;
    bus.ld_instr = v;
    if (model_buf.size() < DEPTH) model_buf.push_back(v);
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic start_run();
    foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_buf.delete();
  endtask

  task automatic run_to_done(int budget, bit rnd);
    int k = 0;
    while (!bus.done && k < budget) begin
      if (rnd) begin
        bus.stall    = ($urandom_range(0, 2) == 0);
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_instr = INSTR_W'($urandom);
      end
      tick();
      k++;
    end
    bus.stall    = 1'b0;
    bus.ld_valid = 1'b0;
    check("done_reached", 32'(bus.done), 32'd1);
    if (rnd && $urandom_range(0, 1) == 1) begin
      bus.stall = 1'b1;
      tick();
      check("done_stall_hold_vld", 32'(bus.instr_valid), 32'd1);
      bus.stall = 1'b0;
    end
    tick();
    check("drain_vld", 32'(bus.instr_valid), 32'd0);
    check("drain_nop", 32'(bus.instr), 32'(NOP_INSTR));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a new instruction appears only after an edge that saw stall low.
  initial begin
    logic   edge_stall;
    instr_t last;
    instr_t e;
    last = '0;
    forever begin
      @(posedge clk);
      edge_stall = bus.stall;
      @(negedge clk);
      if (bus.instr_valid) begin
        if (edge_stall) begin
          check("stall_hold", 32'(bus.instr), 32'(last));
        end else if (exp_q.size() == 0) begin
          check("unexpected_instr", 32'(bus.instr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream", 32'(bus.instr), 32'(e));
          last = e;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t v;
    int     n;

    bus.clear    = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_instr = '0;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_vld", 32'(bus.instr_valid), 32'd0);
    check("rst_full", 32'(bus.ld_full), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    rst_n = 1'b1;
    tick();

    // Three-instruction program, done timing.
    load(25'h0000001);
    load(25'h0ABCDEF);
    load(25'h1FFFFFF);
    start_run();
    tick();
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_done_e1", 32'(bus.done), 32'd0);
    tick();
    check("t1_done_e2", 32'(bus.done), 32'd0);
    tick();
    check("t1_done_e3", 32'(bus.done), 32'd1);
    check("t1_last_vld", 32'(bus.instr_valid), 32'd1);
    run_to_done(5, 1'b0);

    // Stall hold while mem[1] is presented.
    do_clear();
    for (int i = 0; i < 4; i++) load(INSTR_W'(32'h100 + i));
    start_run();
    tick();
    tick();
    check("t2_instr", 32'(bus.instr), 32'h101);
    check("t2_pc", 32'(bus.pc), 32'd2);
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_hold_instr", 32'(bus.instr), 32'h101);
      check("t2_hold_pc", 32'(bus.pc), 32'd2);
    end
    bus.stall = 1'b0;
    run_to_done(10, 1'b0);

    // Full buffer, overflow write dropped.
    do_clear();
    for (int i = 0; i < DEPTH; i++) load(INSTR_W'(i));
    check("t3_full", 32'(bus.ld_full), 32'd1);
    load(25'h1234567);
    check("t3_full_after", 32'(bus.ld_full), 32'd1);
    start_run();
    run_to_done(DEPTH + 5, 1'b0);

    // Start on empty buffer; start coinciding with a load.
    do_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t4_empty_busy", 32'(bus.busy), 32'd0);
    check("t4_empty_vld", 32'(bus.instr_valid), 32'd0);
    v = INSTR_W'($urandom);
    bus.start    = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_instr = v;
    model_buf.push_back(v);
    tick();
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    check("t4_ldstart_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t4_ldstart_idle", 32'(bus.busy), 32'd0);
    start_run();
    run_to_done(5, 1'b0);

    // Asynchronous reset mid-stream.
    do_clear();
    for (int i = 0; i < 4; i++) load(INSTR_W'($urandom));
    start_run();
    tick();
    tick();
    check("t5_pc_before", 32'(bus.pc), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", 32'(bus.instr_valid), 32'd0);
    check("t5_rst_pc", 32'(bus.pc), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    model_buf.delete();
    tick();
    rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_start_ignored", 32'(bus.busy), 32'd0);
    tick();
    check("t5_still_idle", 32'(bus.instr_valid), 32'd0);

    // Clear beats start in DONE; next load lands at mem[0].
    load(INSTR_W'($urandom));
    load(INSTR_W'($urandom));
    start_run();
    run_to_done(10, 1'b0);
    check("t6_in_done", 32'(bus.done), 32'd1);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    model_buf.delete();
    check("t6_done_cleared", 32'(bus.done), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_full", 32'(bus.ld_full), 32'd0);
    load(25'h0055AA5);
    start_run();
    run_to_done(5, 1'b0);

    // Randomized programs with stalls and ignored loads during streaming.
    for (int it = 0; it < 20; it++) begin
      do_clear();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        load(INSTR_W'($urandom));
      end
      start_run();
      run_to_done(n * 4 + 20, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
